// File: rtl/data_mem_sync.sv
// Synchronous data memory: registered read with write-first bypass,
// a zero-fill sweep after reset or on request, and a sticky busy-access flag.
module data_mem_sync #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wen,
    input  logic              ren,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              clr_req,
    output logic [DATA_W-1:0] read_data,
    output logic              rvalid,
    output logic              ready,
    output logic              err
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam state_t RST_STATE =
        (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

    state_t state;
    state_t state_nxt;

    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              acc_wr;
    logic              acc_rd;
    logic              sweep_end;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd;

    assign ready     = (state == IDLE);
    assign acc_wr    = wen & ready;
    assign acc_rd    = ren & ready;
    assign sweep_end = (state == CLEAR)
                     && (cnt == {ADDR_W{1'b1}});

    // Sweep owns the write port whenever not ready.
    assign mem_we   = acc_wr | (state == CLEAR);
    assign mem_addr = ready ? addr : cnt;
    assign mem_wd   = ready ? write_data : '0;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                if (sweep_end) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = RST_STATE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_STATE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data <= '0;
            rvalid    <= 1'b0;
            err       <= 1'b0;
        end else begin
            rvalid <= acc_rd;
            if (acc_rd) begin
                read_data <= acc_wr ? write_data : mem[addr];
            end
            if ((wen | ren) & ~ready) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_sync.sv
// Directed bench for data_mem_sync: default 8x256 sweeping instance
// plus a 16x16 instance without reset sweep.
module tb_data_mem_sync;

    logic       clk;
    logic       rst_n;
    logic       wen;
    logic       ren;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       clr_req;
    logic [7:0] rdata;
    logic       rvalid;
    logic       ready;
    logic       err;

    logic        rst2_n;
    logic        wen2;
    logic        ren2;
    logic [3:0]  addr2;
    logic [15:0] wdata2;
    logic        clr2;
    logic [15:0] rdata2;
    logic        rvalid2;
    logic        ready2;
    logic        err2;

    int checks;
    int failures;

    data_mem_sync dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wen       (wen),
        .ren       (ren),
        .addr      (addr),
        .write_data(wdata),
        .clr_req   (clr_req),
        .read_data (rdata),
        .rvalid    (rvalid),
        .ready     (ready),
        .err       (err)
    );

    data_mem_sync #(
        .DATA_W        (16),
        .ADDR_W        (4),
        .CLEAR_ON_RESET(0)
    ) dut2 (
        .clk       (clk),
        .rst_n     (rst2_n),
        .wen       (wen2),
        .ren       (ren2),
        .addr      (addr2),
        .write_data(wdata2),
        .clr_req   (clr2),
        .read_data (rdata2),
        .rvalid    (rvalid2),
        .ready     (ready2),
        .err       (err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_in();
        wen     = 1'b0;
        ren     = 1'b0;
        clr_req = 1'b0;
    endtask

    // Counts negedges with ready low, starting at the current one.
    task automatic count_busy(output int n);
        n = 0;
        while (!ready && n < 400) begin
            n++;
            cyc();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_in();
        addr  = '0;
        wdata = '0;
        cyc();
        cyc();
        checks++;
        if (rdata !== 8'h00 || rvalid !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outs: rd=%h rv=%b err=%b want 00 0 0",
                     rdata, rvalid, err);
        end
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got %b want 0", ready);
        end
    endtask

    task automatic test_sweep_after_reset();
        int n;
        int bad;
        rst_n = 1'b1;
        count_busy(n);
        checks++;
        if (n != 256) begin
            failures++;
            $display("FAIL init_sweep_len: got %0d want 256", n);
        end
        bad = 0;
        ren = 1'b1;
        for (int i = 0; i < 256; i++) begin
            addr = 8'(i);
            cyc();
            if (rvalid !== 1'b1 || rdata !== 8'h00) bad++;
        end
        ren = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL init_zero: %0d bad reads want 0", bad);
        end
        cyc();
        checks++;
        if (rvalid !== 1'b0) begin
            failures++;
            $display("FAIL rvalid_drop: got %b want 0", rvalid);
        end
    endtask

    task automatic test_write_read();
        wen   = 1'b1;
        addr  = 8'h10;
        wdata = 8'hA5;
        cyc();
        checks++;
        if (rvalid !== 1'b0) begin
            failures++;
            $display("FAIL wr_no_rvalid: got %b want 0", rvalid);
        end
        wen = 1'b0;
        ren = 1'b1;
        cyc();
        ren = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 8'hA5) begin
            failures++;
            $display("FAIL wr_rd: rv=%b rd=%h want 1 a5", rvalid, rdata);
        end
        addr = 8'h00;
        cyc();
        checks++;
        if (rvalid !== 1'b0 || rdata !== 8'hA5) begin
            failures++;
            $display("FAIL rd_hold: rv=%b rd=%h want 0 a5", rvalid, rdata);
        end
    endtask

    task automatic test_write_first();
        wen   = 1'b1;
        ren   = 1'b1;
        addr  = 8'h20;
        wdata = 8'h3C;
        cyc();
        wen = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 8'h3C) begin
            failures++;
            $display("FAIL wr_first: rv=%b rd=%h want 1 3c", rvalid, rdata);
        end
        cyc();
        ren = 1'b0;
        checks++;
        if (rdata !== 8'h3C) begin
            failures++;
            $display("FAIL wr_first_mem: got %h want 3c", rdata);
        end
    endtask

    task automatic test_read_then_write();
        wen   = 1'b1;
        addr  = 8'h30;
        wdata = 8'h11;
        cyc();
        wen = 1'b0;
        ren = 1'b1;
        cyc();
        ren   = 1'b0;
        wen   = 1'b1;
        wdata = 8'h22;
        cyc();
        wen = 1'b0;
        checks++;
        if (rdata !== 8'h11 || rvalid !== 1'b0) begin
            failures++;
            $display("FAIL rd_then_wr: rd=%h rv=%b want 11 0", rdata, rvalid);
        end
        ren = 1'b1;
        cyc();
        ren = 1'b0;
        checks++;
        if (rdata !== 8'h22) begin
            failures++;
            $display("FAIL rd_after_wr: got %h want 22", rdata);
        end
    endtask

    task automatic test_clr_req();
        int n;
        logic rv_seen;
        wen   = 1'b1;
        addr  = 8'h05;
        wdata = 8'hFF;
        cyc();
        wen     = 1'b0;
        ren     = 1'b1;
        clr_req = 1'b1;
        cyc();
        idle_in();
        checks++;
        if (rvalid !== 1'b1 || rdata !== 8'hFF || ready !== 1'b0) begin
            failures++;
            $display("FAIL clr_same_cyc: rv=%b rd=%h rdy=%b want 1 ff 0",
                     rvalid, rdata, ready);
        end
        n = 0;
        rv_seen = 1'b0;
        while (!ready && n < 400) begin
            n++;
            ren     = (n == 50);
            clr_req = (n == 50);
            if (n == 51 && rvalid !== 1'b0) rv_seen = 1'b1;
            cyc();
        end
        idle_in();
        checks++;
        if (n != 256) begin
            failures++;
            $display("FAIL clr_sweep_len: got %0d want 256", n);
        end
        checks++;
        if (rv_seen !== 1'b0) begin
            failures++;
            $display("FAIL busy_rvalid: got 1 want 0");
        end
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_set: got %b want 1", err);
        end
        addr = 8'h05;
        ren  = 1'b1;
        cyc();
        ren = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 8'h00) begin
            failures++;
            $display("FAIL clr_zero: rv=%b rd=%h want 1 00", rvalid, rdata);
        end
        cyc();
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky: got %b want 1", err);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        wen   = 1'b1;
        ren   = 1'b1;
        addr  = 8'h40;
        wdata = 8'h5A;
        cyc();
        idle_in();
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        repeat (100) cyc();
        rst_n = 1'b0;
        #1;
        checks++;
        if (rdata !== 8'h00 || rvalid !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_outs: rd=%h rv=%b err=%b want 00 0 0",
                     rdata, rvalid, err);
        end
        cyc();
        rst_n = 1'b1;
        count_busy(n);
        checks++;
        if (n != 256) begin
            failures++;
            $display("FAIL mid_rst_sweep: got %0d want 256", n);
        end
        checks++;
        if (err !== 1'b0 || rdata !== 8'h00) begin
            failures++;
            $display("FAIL mid_rst_after: err=%b rd=%h want 0 00", err, rdata);
        end
        addr = 8'h40;
        ren  = 1'b1;
        cyc();
        ren = 1'b0;
        checks++;
        if (rdata !== 8'h00) begin
            failures++;
            $display("FAIL mid_rst_zero: got %h want 00", rdata);
        end
    endtask

    task automatic test_small_cfg();
        int n;
        rst2_n = 1'b0;
        cyc();
        checks++;
        if (ready2 !== 1'b1 || rdata2 !== 16'h0000) begin
            failures++;
            $display("FAIL s_rst: rdy=%b rd=%h want 1 0000", ready2, rdata2);
        end
        rst2_n = 1'b1;
        wen2   = 1'b1;
        addr2  = 4'hF;
        wdata2 = 16'hBEEF;
        cyc();
        wen2 = 1'b0;
        ren2 = 1'b1;
        cyc();
        ren2 = 1'b0;
        checks++;
        if (rvalid2 !== 1'b1 || rdata2 !== 16'hBEEF) begin
            failures++;
            $display("FAIL s_wr_rd: rv=%b rd=%h want 1 beef", rvalid2, rdata2);
        end
        clr2 = 1'b1;
        cyc();
        clr2 = 1'b0;
        n = 0;
        while (!ready2 && n < 100) begin
            n++;
            cyc();
        end
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL s_sweep_len: got %0d want 16", n);
        end
        ren2 = 1'b1;
        cyc();
        ren2 = 1'b0;
        checks++;
        if (rdata2 !== 16'h0000 || err2 !== 1'b0) begin
            failures++;
            $display("FAIL s_zero: rd=%h err=%b want 0000 0", rdata2, err2);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst2_n   = 1'b0;
        wen2     = 1'b0;
        ren2     = 1'b0;
        clr2     = 1'b0;
        addr2    = '0;
        wdata2   = '0;
        test_reset();
        test_sweep_after_reset();
        test_write_read();
        test_write_first();
        test_read_then_write();
        test_clr_req();
        test_reset_mid_sweep();
        test_small_cfg();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_sync.md
DATA_MEM_SYNC -- requirements
Module: data_mem_sync

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, data word width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 8, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL provide parameter CLEAR_ON_RESET, default 1; 1 = zero-fill sweep after reset, 0 = no sweep.
REQ-004 SHALL provide port clk  input  1  system clock, all state on rising edge.
REQ-005 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL provide port wen  input  1  write request (STD, STI).
REQ-007 SHALL provide port ren  input  1  read request (LDD, LDI).
REQ-008 SHALL provide port addr  input  ADDR_W  word address.
REQ-009 SHALL provide port write_data  input  DATA_W  write data.
REQ-010 SHALL provide port clr_req  input  1  request a full zero-fill sweep.
REQ-011 SHALL provide port read_data  output  DATA_W  registered read data.
REQ-012 SHALL provide port rvalid  output  1  one-cycle pulse, read_data updated this cycle.
REQ-013 SHALL provide port ready  output  1  block accepts wen/ren this cycle.
REQ-014 SHALL provide port err  output  1  sticky flag, access attempted while ready=0.

Function
REQ-015 SHALL implement FSM with states IDLE and CLEAR; ready = 1 exactly in IDLE.
REQ-016 Access accepted SHALL mean (wen or ren) and ready=1 at a rising clk edge.
REQ-017 Accepted write SHALL store write_data at addr on that edge.
REQ-018 Accepted read SHALL load read_data with mem[addr] on that edge; rvalid=1 in the following cycle only (latency 1).
REQ-019 Accepted wen and ren to the same addr in one cycle SHALL return the new write_data (write-first).
REQ-020 Accepted read followed next cycle by write to same addr SHALL NOT alter the already-registered read_data.
REQ-021 read_data SHALL hold its last value when no read is accepted; rvalid=0.
REQ-022 wen/ren with ready=0 SHALL be ignored (no write, no rvalid) and SHALL set err=1.
REQ-023 err SHALL clear only on reset.
REQ-024 CLEAR SHALL write 0 to address counter location, counter 0 to DEPTH-1, one word per cycle; exactly DEPTH cycles in CLEAR.
REQ-025 CLEAR -> IDLE SHALL occur on the edge writing address DEPTH-1; ready=1 in the next cycle.
REQ-026 IDLE -> CLEAR SHALL occur when clr_req=1 in IDLE; any wen/ren in that same cycle SHALL be accepted first, then sweep starts at address 0 next cycle.
REQ-027 clr_req during CLEAR SHALL be ignored (no restart).
REQ-028 Address counter SHALL be ADDR_W+1 bits or compare-terminated; no wrap back into a second sweep.
REQ-029 Memory array SHALL NOT be reset by rst_n; content after reset is defined only by sweep (CLEAR_ON_RESET=1).

Reset
REQ-030 rst_n=0 SHALL asynchronously force read_data=0, rvalid=0, err=0, address counter=0.
REQ-031 rst_n=0 SHALL force state CLEAR (ready=0) if CLEAR_ON_RESET=1, else IDLE (ready=1).
REQ-032 Reset asserted mid-sweep SHALL restart the sweep from address 0 after deassertion.
REQ-033 First sweep write SHALL occur on the first rising clk edge with rst_n=1.

Verification
REQ-034 Defaults, release reset, ren=0 -> ready=0 for 256 cycles, ready=1 cycle 257; read all 256 addresses -> 8'h00 each.
REQ-035 Write 8'hA5 to 8'h10, next cycle read 8'h10 -> read_data=8'hA5 with rvalid one cycle after ren, rvalid low afterwards.
REQ-036 Same cycle wen=1, ren=1, addr=8'h20, write_data=8'h3C -> next cycle read_data=8'h3C, rvalid=1.
REQ-037 clr_req after writing 8'hFF to 8'h05 -> ready=0 for 256 cycles; ren during sweep -> err=1, no rvalid; after sweep read 8'h05 -> 8'h00.
REQ-038 Assert rst_n=0 at sweep address 100, release -> ready=0 for full 256 cycles again, err=0, read_data=0.
REQ-039 DATA_W=16, ADDR_W=4, CLEAR_ON_RESET=0 -> ready=1 immediately after reset; write 16'hBEEF to 4'hF, read -> 16'hBEEF; clr_req -> 16-cycle sweep.
